cix32_muldiv_seq: RTL and testbench

CIX32_MULDIV_SEQ -- requirements
Module: cix32_muldiv_seq

---
 rtl/cix32_muldiv_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_cix32_muldiv_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cix32_muldiv_seq.sv
// Sequential 32-bit MUL/IMUL/DIV/IDIV unit: shift-add multiply and restoring divide,
// retiring BITS_PER_CYCLE result bits per iteration cycle.
module cix32_muldiv_seq #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [1:0]  op,
  input  logic [31:0] src_a_hi,
  input  logic [31:0] src_a_lo,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        cf_of,
  output logic        div_err,
  output logic        busy
);

  localparam int unsigned ITERS = 32 / BITS_PER_CYCLE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL,
    OP_IMUL,
    OP_DIV,
    OP_IDIV
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        ovf_q, ovf_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic        cf_q, cf_d;
  logic        err_q, err_d;

  logic        is_signed;
  logic [31:0] mag_b, mag_alo;
  logic [63:0] mag_dvd, prod;
  logic [31:0] quo_s, rem_s;
  logic        idiv_ovf;
  logic        prep_err;
  logic [63:0] step_acc;
  logic [64:0] shifted;
  logic [32:0] trial, sum;

  // One iteration cycle: BITS_PER_CYCLE chained steps. During DIV/IDIV acc holds
  // {partial remainder, dividend/quotient}; during MUL/IMUL {partial product, multiplier}.
  always_comb begin
    step_acc = acc_q;
    shifted  = '0;
    trial    = '0;
    sum      = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[1]) begin
        shifted  = {step_acc, 1'b0};
        trial    = shifted[64:32] - {1'b0, opb_q};
        step_acc = trial[32] ? shifted[63:0] : {trial[31:0], shifted[31:1], 1'b1};
      end else begin
        sum      = {1'b0, step_acc[63:32]} + (step_acc[0] ? {1'b0, opb_q} : 33'd0);
        step_acc = {sum, step_acc[31:1]};
      end
    end
  end

  always_comb begin
    is_signed = op_q[0];
    mag_b     = (is_signed && opb_q[31]) ? -opb_q : opb_q;
    mag_alo   = (is_signed && acc_q[31]) ? -acc_q[31:0] : acc_q[31:0];
    mag_dvd   = (is_signed && acc_q[63]) ? -acc_q : acc_q;
    prod      = quo_neg_q ? -acc_q : acc_q;
    quo_s     = quo_neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem_s     = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
    // A negative quotient may reach 2^31 in magnitude; a positive one may not.
    idiv_ovf  = ovf_q || (quo_neg_q ? (acc_q[31:0] > 32'h8000_0000) : acc_q[31]);
    prep_err  = op_q[1] && ((opb_q == '0) || (!is_signed && (acc_q[63:32] >= opb_q)));

    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    cf_d      = cf_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          op_d    = op_e'(op);
          acc_d   = {src_a_hi, src_a_lo};
          opb_d   = src_b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        cnt_d     = 6'(ITERS);
        quo_neg_d = 1'b0;
        rem_neg_d = 1'b0;
        ovf_d     = 1'b0;
        if (prep_err) begin
          res_lo_d = '0;
          res_hi_d = '0;
          cf_d     = 1'b0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_ITER;
          if (!op_q[1]) begin
            acc_d     = {32'd0, mag_b};
            opb_d     = mag_alo;
            quo_neg_d = is_signed && (acc_q[31] ^ opb_q[31]);
          end else begin
            acc_d     = mag_dvd;
            opb_d     = mag_b;
            quo_neg_d = is_signed && (acc_q[63] ^ opb_q[31]);
            rem_neg_d = is_signed && acc_q[63];
            // Dividend high half >= divisor means the quotient needs more than 32 bits.
            ovf_d     = is_signed && (mag_dvd[63:32] >= mag_b);
          end
        end
      end
      S_ITER: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        cf_d    = 1'b0;
        err_d   = 1'b0;
        state_d = S_DONE;
        unique case (op_q)
          OP_MUL: begin
            res_lo_d = acc_q[31:0];
            res_hi_d = acc_q[63:32];
            cf_d     = |acc_q[63:32];
          end
          OP_IMUL: begin
            res_lo_d = prod[31:0];
            res_hi_d = prod[63:32];
            cf_d     = prod[63:32] != {32{prod[31]}};
          end
          OP_DIV: begin
            res_lo_d = acc_q[31:0];
            res_hi_d = acc_q[63:32];
          end
          OP_IDIV: begin
            if (idiv_ovf) begin
              res_lo_d = '0;
              res_hi_d = '0;
              err_d    = 1'b1;
            end else begin
              res_lo_d = quo_s;
              res_hi_d = rem_s;
            end
          end
          default: ;
        endcase
      end
      S_DONE: begin
        if (done_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      acc_q     <= '0;
      opb_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      cf_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      cf_q      <= cf_d;
      err_q     <= err_d;
    end
  end

  // Result registers are only visible in DONE so every other state reads as zero.
  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done_valid  = (state_q == S_DONE);
  assign result_lo   = done_valid ? res_lo_q : '0;
  assign result_hi   = done_valid ? res_hi_q : '0;
  assign cf_of       = done_valid & cf_q;
  assign div_err     = done_valid & err_q;

endmodule

// File: tb/tb_cix32_muldiv_seq.sv
// Scoreboard bench for cix32_muldiv_seq: three instances (1, 2 and 4 bits per cycle)
// with expected results queued at issue and compared when done_valid rises.
module tb_cix32_muldiv_seq;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        cf;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a_hi = '0;
  logic [31:0] a_lo = '0;
  logic [31:0] b = '0;
  logic [2:0]  sv = '0;
  logic [2:0]  fl = '0;
  logic [2:0]  dr = '0;
  logic [2:0]  srdy, dv, cf, de, bsy;
  logic [31:0] rlo [3];
  logic [31:0] rhi [3];

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   lat_tab [3] = '{35, 19, 11};

  always #5 clk = ~clk;

  cix32_muldiv_seq #(.BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(srdy[0]), .op(op),
    .src_a_hi(a_hi), .src_a_lo(a_lo), .src_b(b), .flush(fl[0]), .done_valid(dv[0]),
    .done_ready(dr[0]), .result_lo(rlo[0]), .result_hi(rhi[0]), .cf_of(cf[0]),
    .div_err(de[0]), .busy(bsy[0]));

  cix32_muldiv_seq #(.BITS_PER_CYCLE(2)) u_bpc2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(srdy[1]), .op(op),
    .src_a_hi(a_hi), .src_a_lo(a_lo), .src_b(b), .flush(fl[1]), .done_valid(dv[1]),
    .done_ready(dr[1]), .result_lo(rlo[1]), .result_hi(rhi[1]), .cf_of(cf[1]),
    .div_err(de[1]), .busy(bsy[1]));

  cix32_muldiv_seq #(.BITS_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(srdy[2]), .op(op),
    .src_a_hi(a_hi), .src_a_lo(a_lo), .src_b(b), .flush(fl[2]), .done_valid(dv[2]),
    .done_ready(dr[2]), .result_lo(rlo[2]), .result_hi(rhi[2]), .cf_of(cf[2]),
    .div_err(de[2]), .busy(bsy[2]));

  // Reference model built on native 64-bit arithmetic.
  function automatic exp_t model(int d, logic [1:0] o, logic [31:0] h, logic [31:0] l,
                                 logic [31:0] bb);
    exp_t e;
    logic [63:0] p;
    logic signed [63:0] sd, dvs, sq, sr;
    e.lo = '0; e.hi = '0; e.cf = 1'b0; e.err = 1'b0; e.lat = (32 >> d) + 3;
    case (o)
      2'd0: begin
        p = {32'd0, l} * {32'd0, bb};
        e.lo = p[31:0]; e.hi = p[63:32]; e.cf = (p[63:32] != '0);
      end
      2'd1: begin
        sd = $signed({{32{l[31]}}, l}) * $signed({{32{bb[31]}}, bb});
        e.lo = sd[31:0]; e.hi = sd[63:32]; e.cf = (sd[63:32] != {32{sd[31]}});
      end
      2'd2: begin
        if (bb == '0 || h >= bb) begin
          e.err = 1'b1; e.lat = 2;
        end else begin
          p = {h, l} / {32'd0, bb}; e.lo = p[31:0];
          p = {h, l} % {32'd0, bb}; e.hi = p[31:0];
        end
      end
      default: begin
        if (bb == '0) begin
          e.err = 1'b1; e.lat = 2;
        end else begin
          sd  = $signed({h, l});
          dvs = $signed({{32{bb[31]}}, bb});
          if (sd == 64'sh8000_0000_0000_0000 && dvs == -64'sd1) begin
            e.err = 1'b1;
          end else begin
            sq = sd / dvs;
            sr = sd % dvs;
            if (sq > 64'sd2147483647 || sq < -64'sd2147483648) e.err = 1'b1;
            else begin e.lo = sq[31:0]; e.hi = sr[31:0]; end
          end
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue_exp(int d, logic [1:0] o, logic [31:0] h, logic [31:0] l,
                           logic [31:0] bb, exp_t e);
    int t = 0;
    sb.push_back(e);
    op = o; a_hi = h; a_lo = l; b = bb; sv[d] = 1'b1;
    while (!srdy[d] && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    sv[d] = 1'b0;
    op = 2'($urandom); a_hi = $urandom; a_lo = $urandom; b = $urandom;
  endtask

  task automatic issue(int d, logic [1:0] o, logic [31:0] h, logic [31:0] l, logic [31:0] bb);
    issue_exp(d, o, h, l, bb, model(d, o, h, l, bb));
  endtask

  task automatic collect(int d, int hold, bit sv_next);
    exp_t e;
    int lat = 0;
    bit got = 1'b0;
    while (!got && lat < 200) begin @(negedge clk); lat++; got = dv[d]; end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard dut%0d: got empty queue, want a pending entry", d);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      miscompares++;
      $display("FAIL done_timeout dut%0d: got no done_valid in 200 cycles, want latency %0d", d, e.lat);
      return;
    end
    vectors += 4;
    if (lat !== e.lat) begin
      miscompares++; $display("FAIL latency dut%0d: got %0d want %0d", d, lat, e.lat);
    end
    if ({rhi[d], rlo[d]} !== {e.hi, e.lo}) begin
      miscompares++;
      $display("FAIL result dut%0d: got %h:%h want %h:%h", d, rhi[d], rlo[d], e.hi, e.lo);
    end
    if (cf[d] !== e.cf) begin
      miscompares++; $display("FAIL cf_of dut%0d: got %b want %b", d, cf[d], e.cf);
    end
    if (de[d] !== e.err) begin
      miscompares++; $display("FAIL div_err dut%0d: got %b want %b", d, de[d], e.err);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if ({dv[d], srdy[d], rhi[d], rlo[d], cf[d], de[d]} !== {1'b1, 1'b0, e.hi, e.lo, e.cf, e.err}) begin
        miscompares++;
        $display("FAIL hold_stable dut%0d cycle %0d: got dv=%b rdy=%b %h:%h cf=%b err=%b want dv=1 rdy=0 %h:%h cf=%b err=%b",
                 d, i, dv[d], srdy[d], rhi[d], rlo[d], cf[d], de[d], e.hi, e.lo, e.cf, e.err);
      end
    end
    if (sv_next) sv[d] = 1'b1;
    dr[d] = 1'b1;
    @(posedge clk); #1;
    dr[d] = 1'b0;
    vectors++;
    if ({srdy[d], dv[d], bsy[d]} !== 3'b100) begin
      miscompares++;
      $display("FAIL after_handshake dut%0d: got rdy/dv/busy=%b want 100", d, {srdy[d], dv[d], bsy[d]});
    end
  endtask

  task automatic check_quiet(int d, int cycles, string name);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin @(negedge clk); seen |= dv[d]; end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL %s dut%0d: got done_valid=1 want 0", name, d);
    end
  endtask

  task automatic check_idle_outputs(int d, string name);
    vectors++;
    if ({srdy[d], dv[d], bsy[d], cf[d], de[d], rhi[d], rlo[d]} !== {5'b10000, 64'd0}) begin
      miscompares++;
      $display("FAIL %s dut%0d: got rdy=%b dv=%b busy=%b cf=%b err=%b %h:%h want rdy=1 rest 0",
               name, d, srdy[d], dv[d], bsy[d], cf[d], de[d], rhi[d], rlo[d]);
    end
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < 3; d++) check_idle_outputs(d, "reset_state");
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul();
    for (int d = 0; d < 3; d++) begin
      issue_exp(d, 2'd0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                '{lo: 32'h0000_0001, hi: 32'hFFFF_FFFE, cf: 1'b1, err: 1'b0, lat: lat_tab[d]});
      collect(d, 0, 1'b0);
    end
  endtask

  task automatic test_imul();
    issue_exp(0, 2'd1, 32'h0, 32'hFFFF_FFFD, 32'd5,
              '{lo: 32'hFFFF_FFF1, hi: 32'hFFFF_FFFF, cf: 1'b0, err: 1'b0, lat: 35});
    collect(0, 0, 1'b0);
    issue_exp(0, 2'd1, 32'h0, 32'h0001_0000, 32'h0001_0000,
              '{lo: 32'h0, hi: 32'h1, cf: 1'b1, err: 1'b0, lat: 35});
    collect(0, 0, 1'b0);
  endtask

  task automatic test_div();
    for (int d = 0; d < 3; d++) begin
      issue_exp(d, 2'd2, 32'h0, 32'd100, 32'd7,
                '{lo: 32'd14, hi: 32'd2, cf: 1'b0, err: 1'b0, lat: lat_tab[d]});
      collect(d, 0, 1'b0);
      issue_exp(d, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7,
                '{lo: 32'hFFFF_FFF2, hi: 32'hFFFF_FFFE, cf: 1'b0, err: 1'b0, lat: lat_tab[d]});
      collect(d, 0, 1'b0);
    end
  endtask

  task automatic test_div_err();
    issue_exp(0, 2'd2, 32'h0, 32'h1234_5678, 32'd0,
              '{lo: 32'h0, hi: 32'h0, cf: 1'b0, err: 1'b1, lat: 2});
    collect(0, 0, 1'b0);
    issue_exp(0, 2'd2, 32'h1, 32'h0, 32'h1,
              '{lo: 32'h0, hi: 32'h0, cf: 1'b0, err: 1'b1, lat: 2});
    collect(0, 0, 1'b0);
    issue_exp(0, 2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
              '{lo: 32'h0, hi: 32'h0, cf: 1'b0, err: 1'b1, lat: 35});
    collect(0, 0, 1'b0);
  endtask

  task automatic test_hold();
    issue_exp(0, 2'd2, 32'h0, 32'd100, 32'd7,
              '{lo: 32'd14, hi: 32'd2, cf: 1'b0, err: 1'b0, lat: 35});
    collect(0, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 3; d += 2) begin
      issue(d, 2'd1, 32'h0, 32'h8000_0001, 32'h7FFF_FFFF);
      collect(d, 0, 1'b1);
      issue(d, 2'd0, 32'h0, 32'hDEAD_BEEF, 32'h0000_1234);
      collect(d, 0, 1'b0);
    end
  endtask

  task automatic test_flush();
    // flush wins over a start presented in IDLE
    @(negedge clk);
    op = 2'd0; a_lo = 32'd9; b = 32'd9; sv[0] = 1'b1; fl[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0; fl[0] = 1'b0;
    check_idle_outputs(0, "flush_vs_start");
    // flush during the 10th ITER cycle
    op = 2'd0; a_lo = 32'h1111_1111; b = 32'h2222_2222; sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 fl[0] = 1'b1;
    @(posedge clk); #1;
    fl[0] = 1'b0;
    check_idle_outputs(0, "flush_iter");
    check_quiet(0, 40, "flush_iter_no_done");
    issue_exp(0, 2'd0, 32'h0, 32'd3, 32'd4, '{lo: 32'd12, hi: 32'd0, cf: 1'b0, err: 1'b0, lat: 35});
    collect(0, 0, 1'b0);
    // flush while a result waits in DONE
    op = 2'd2; a_hi = '0; b = '0; sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (dv[0] !== 1'b1) begin
      miscompares++; $display("FAIL flush_done_setup dut0: got done_valid=%b want 1", dv[0]);
    end
    fl[0] = 1'b1;
    @(posedge clk); #1;
    fl[0] = 1'b0;
    check_idle_outputs(0, "flush_done");
    check_quiet(0, 10, "flush_done_no_done");
  endtask

  task automatic test_reset_mid();
    op = 2'd0; a_lo = 32'h5555_5555; b = 32'h3333_3333; sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs(0, "reset_mid_iter");
    @(negedge clk); rst_n = 1'b1;
    check_quiet(0, 40, "reset_mid_no_done");
    issue_exp(0, 2'd0, 32'h0, 32'd3, 32'd4, '{lo: 32'd12, hi: 32'd0, cf: 1'b0, err: 1'b0, lat: 35});
    collect(0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] h, l, bb;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 12; n++) begin
        o = 2'(n % 4); l = $urandom; bb = $urandom; h = $urandom;
        if (n % 3 == 0) bb = bb >> $urandom_range(0, 31);
        if (o == 2'd2 && bb != '0 && $urandom_range(0, 3) != 0) h = $urandom % bb;
        if (o == 2'd3 && $urandom_range(0, 3) != 0) h = {32{l[31]}};
        issue(d, o, h, l, bb);
        collect(d, n % 3, 1'b0);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mul();
    test_imul();
    test_div();
    test_div_err();
    test_hold();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
